// File: rtl/minority_voter_seq.sv
// Bit-serial minority/majority voter: accepts a WIDTH-bit vector, counts its ones
// one bit per clock, then presents a registered vote, tie flag and ones count.
module minority_voter_seq #(
    parameter int unsigned WIDTH   = 4,
    parameter bit          TIE_VAL = 1'b0,
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             OUT,
    output logic             TIE,
    output logic [CNT_W-1:0] ONES,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    // One extra bit so 2*ones never overflows when compared with WIDTH.
    localparam int unsigned      CMP_W    = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CMP_W-1:0] WIDTH_C  = CMP_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             mode_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;
    logic             accept;
    logic [CNT_W-1:0] ones_next;
    logic [CMP_W-1:0] twice;
    logic             tie_next;
    logic             vote_next;

    assign IN_READY  = (state == IDLE) && !RST;
    assign OUT_VALID = (state == DONE);
    assign accept    = IN_VALID && IN_READY;

    // Vote for the count as it will stand after the current step.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        vote_next = 1'b0;
        ones_next = count + CNT_W'(shreg[0]);
        twice     = {ones_next, 1'b0};
        tie_next  = (twice == WIDTH_C);
        if (tie_next)
            vote_next = TIE_VAL;
        else if (mode_q)
            vote_next = (twice > WIDTH_C);
        else
            vote_next = (twice < WIDTH_C);
    end

    // NOTE: shreg and mode_q carry no reset; they are always reloaded on acceptance before use.
    always_ff @(posedge CLK) begin
        if (accept) begin
            shreg  <= IN;
            mode_q <= MODE;
        end else if (state == COUNT) begin
            shreg  <= shreg >> 1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            OUT   <= 1'b0;
            TIE   <= 1'b0;
            ONES  <= '0;
            count <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= COUNT;
                        count <= '0;
                        idx   <= '0;
                    end
                end
                COUNT: begin
                    count <= ones_next;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        OUT   <= vote_next;
                        TIE   <= tie_next;
                        ONES  <= ones_next;
                    end
                end
                DONE: begin
                    if (OUT_READY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/minority_voter_seq.md
Name: minority_voter_seq

Overview:
Parametrised, bit-serial minority/majority voter for WIDTH-bit input vectors. It supersedes the fixed 4-input combinational minority function. A vector is accepted through a valid/ready handshake, and its ones are counted one bit per clock. A registered vote (minority or majority, selected per transaction), a tie flag and the ones count are then presented on a valid/ready output. It sits between a vector source and a downstream consumer that can stall.

Parameters:
WIDTH, 4, number of voter inputs; legal range 1..255.
TIE_VAL, 0, OUT value when ones*2 == WIDTH (only reachable for even WIDTH).
CNT_W, $clog2(WIDTH+1), width of the ones counter; derived, never overridden.

Ports:
CLK  in  1  single clock; all state changes on its rising edge.
RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
IN  in  WIDTH  vector to vote on; sampled only on the acceptance edge.
MODE  in  1  0 = minority, 1 = majority; sampled with IN.
IN_VALID  in  1  source has a vector on IN/MODE.
IN_READY  out  1  block can accept; acceptance = IN_VALID && IN_READY at a rising edge.
OUT  out  1  vote result.
TIE  out  1  1 when ones*2 == WIDTH.
ONES  out  CNT_W  number of 1s in the accepted vector.
OUT_VALID  out  1  OUT/TIE/ONES hold a result.
OUT_READY  in  1  consumer takes the result; transfer = OUT_VALID && OUT_READY at a rising edge.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. CLK is the clock, RST the reset.
- FSM states: IDLE, COUNT, DONE. IN_READY = (state == IDLE) && !RST. OUT_VALID = (state == DONE).
- Reset: state=IDLE, OUT=0, TIE=0, ONES=0, internal count and bit index =0.
  - OUT_VALID=0 and IN_READY=0 while RST is high. IN_READY=1 in the first cycle after RST falls.
- RST mid-COUNT or mid-DONE: the transaction is discarded, with no OUT_VALID pulse. This is the same as reset from IDLE.
- IDLE -> COUNT on acceptance:
  - IN is latched into a shift register and MODE is latched.
  - count is cleared to 0 and the bit index is cleared to 0.
- COUNT, one step per cycle:
  - count += shreg[0]; the shift register shifts right; index += 1.
  - After exactly WIDTH steps, go to DONE, with OUT, TIE and ONES registered on that same edge.
- Latency: if acceptance happens at edge k, OUT_VALID=1 after edge k+WIDTH.
- Vote rules, evaluated with full-width ones (CNT_W bits) and WIDTH compared without overflow:
  - MODE=0 (minority): OUT = (2*ones < WIDTH) ? 1 : (2*ones == WIDTH) ? TIE_VAL : 0.
  - MODE=1 (majority): OUT = (2*ones > WIDTH) ? 1 : (2*ones == WIDTH) ? TIE_VAL : 0.
  - TIE = (2*ones == WIDTH), independent of MODE.
- DONE: OUT, TIE and ONES are held stable while OUT_READY=0, indefinitely.
  - On transfer, go to IDLE; OUT/TIE/ONES keep their last value and OUT_VALID falls.
- No overlap:
  - IN_READY=0 throughout COUNT and DONE. IN, MODE and IN_VALID changes there are ignored.
  - Minimum spacing between acceptances is WIDTH+2 cycles: WIDTH in COUNT, 1 in DONE with OUT_READY=1, 1 in IDLE.
- WIDTH=1: a single COUNT step; TIE is never 1.
- IN_VALID held high with IN changing before acceptance: only the value on the acceptance edge matters.

Test Plan:
- Reset: hold RST for 3 cycles, then release. IN_READY=0 during reset and 1 the next cycle; OUT_VALID=0, OUT=0, ONES=0.
- WIDTH=4, TIE_VAL=0, MODE=0, OUT_READY=1:
  - IN=0001 -> OUT_VALID 4 cycles after acceptance, ONES=1, OUT=1, TIE=0.
  - IN=0111 -> ONES=3, OUT=0.
  - IN=0000 -> ONES=0, OUT=1.
- WIDTH=4 tie handling:
  - IN=0011, MODE=0 -> TIE=1, OUT=0.
  - Same vector, MODE=1 -> TIE=1, OUT=0.
  - Rebuild with TIE_VAL=1 -> OUT=1 for both modes.
- WIDTH=5, MODE=1:
  - IN=10101 -> ONES=3, OUT=1, latency 5.
  - Same vector, MODE=0 -> OUT=0, TIE=0.
- Backpressure: OUT_READY=0 for 6 cycles in DONE.
  - OUT/ONES stay stable, IN_READY stays 0, and a new IN_VALID is not accepted.
  - Raising OUT_READY transfers once; IN_READY=1 next cycle.
- RST asserted mid-COUNT (WIDTH=4, 2 steps in) -> IN_READY=0 while RST is high and 1 the cycle after release.
  - No OUT_VALID appears for the aborted vector.
  - A new IN=1111 then gives ONES=4, OUT=0 (MODE=0).
